// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM state encoding, the IF/ID payload and PC helpers.
package fetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP           = 32'h0000_0004;

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_WAIT = 2'b01,
    S_HOLD = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load, hold, flush and bubble for {valid, pc, instr}.
// Flush beats load; an unstalled register with nothing to load becomes a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic        hold,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  if_id_t q_r;

  // IF/ID payload register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_r.valid <= 1'b0;
      q_r.pc    <= 32'h0000_0000;
      q_r.instr <= NOP_INSTR;
    end else if (flush) begin
      q_r.valid <= 1'b0;
      q_r.pc    <= q_r.pc;
      q_r.instr <= NOP_INSTR;
    end else if (load) begin
      q_r.valid <= 1'b1;
      q_r.pc    <= pc_in;
      q_r.instr <= instr_in;
    end else if (hold) begin
      q_r <= q_r;
    end else begin
      q_r.valid <= 1'b0;
      q_r.pc    <= q_r.pc;
      q_r.instr <= NOP_INSTR;
    end
  end

  assign valid = q_r.valid;
  assign pc    = q_r.pc;
  assign instr = q_r.instr;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns fetch PC, single-outstanding imem handshake,
// redirect/kill handling and the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  fetch_state_e state_r, state_s;
  logic [31:0]  fetch_pc_r, fetch_pc_s;
  logic [31:0]  hold_buf_r, hold_buf_s;
  logic         kill_r, kill_s;
  logic         run_r;
  logic         can_accept_s;
  logic         ifid_load_s;
  logic         ifid_flush_s;
  logic [31:0]  ifid_instr_s;

  assign can_accept_s = !id_stall || !if_id_valid;

  // Next-state, fetch PC, kill and IF/ID control decode
  always_comb begin
    state_s      = state_r;
    fetch_pc_s   = fetch_pc_r;
    hold_buf_s   = hold_buf_r;
    kill_s       = kill_r;
    ifid_load_s  = 1'b0;
    ifid_flush_s = 1'b0;
    ifid_instr_s = imem_rdata;
    if (redirect_valid) begin
      fetch_pc_s   = align_pc(redirect_pc);
      ifid_flush_s = 1'b1;
      case (state_r)
        S_REQ: begin
          // run_r low means no strobe went out this cycle, so nothing to kill.
          if (run_r) begin
            kill_s  = 1'b1;
            state_s = S_WAIT;
          end else begin
            kill_s  = 1'b0;
            state_s = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            kill_s  = 1'b0;
            state_s = S_REQ;
          end else begin
            kill_s  = 1'b1;
            state_s = S_WAIT;
          end
        end
        S_HOLD: begin
          // Nothing outstanding: drop the buffered word and refetch directly.
          kill_s  = 1'b0;
          state_s = S_REQ;
        end
        default: begin
          kill_s  = 1'b0;
          state_s = S_REQ;
        end
      endcase
    end else begin
      case (state_r)
        S_REQ: begin
          if (run_r) begin
            state_s = S_WAIT;
          end else begin
            state_s = S_REQ;
          end
        end
        S_WAIT: begin
          if (!imem_rvalid) begin
            state_s = S_WAIT;
          end else if (kill_r) begin
            kill_s  = 1'b0;
            state_s = S_REQ;
          end else if (can_accept_s) begin
            ifid_load_s  = 1'b1;
            ifid_instr_s = imem_rdata;
            fetch_pc_s   = seq_pc(fetch_pc_r);
            state_s      = S_REQ;
          end else begin
            hold_buf_s = imem_rdata;
            state_s    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (can_accept_s) begin
            ifid_load_s  = 1'b1;
            ifid_instr_s = hold_buf_r;
            fetch_pc_s   = seq_pc(fetch_pc_r);
            state_s      = S_REQ;
          end else begin
            state_s = S_HOLD;
          end
        end
        default: begin
          kill_s  = 1'b0;
          state_s = S_REQ;
        end
      endcase
    end
  end

  // FSM state, fetch PC, hold buffer and kill flag registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= S_REQ;
      fetch_pc_r <= RESET_PC;
      hold_buf_r <= NOP_INSTR;
      kill_r     <= 1'b0;
      run_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      hold_buf_r <= hold_buf_s;
      kill_r     <= kill_s;
      run_r      <= 1'b1;
    end
  end

  // Strobe is suppressed in the cycle following a reset edge.
  assign imem_req  = (state_r == S_REQ) && run_r;
  assign imem_addr = fetch_pc_r;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (ifid_load_s),
    .flush    (ifid_flush_s),
    .hold     (id_stall),
    .pc_in    (fetch_pc_r),
    .instr_in (ifid_instr_s),
    .valid    (if_id_valid),
    .pc       (if_id_pc),
    .instr    (if_id_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small latency-programmable imem model.
// Memory returns addr ^ 32'hA5A5_A5A5; expected values are hand-computed.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int          n_vec;
  int          n_err;
  int          mem_lat;
  int          mem_cnt;
  logic [31:0] mem_addr;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model, reset together with the fetch stage
  always @(posedge clk) begin
    if (!reset) begin
      mem_cnt     <= 0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0000_0000;
    end else if (imem_req) begin
      mem_addr <= imem_addr;
      if (mem_lat == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= imem_addr ^ 32'hA5A5_A5A5;
        mem_cnt     <= 0;
      end else begin
        imem_rvalid <= 1'b0;
        mem_cnt     <= mem_lat - 1;
      end
    end else if (mem_cnt == 1) begin
      imem_rvalid <= 1'b1;
      imem_rdata  <= mem_addr ^ 32'hA5A5_A5A5;
      mem_cnt     <= 0;
    end else if (mem_cnt > 1) begin
      imem_rvalid <= 1'b0;
      mem_cnt     <= mem_cnt - 1;
    end else begin
      imem_rvalid <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   32'(imem_req),    32'h0000_0000);
    check({tag, "_addr"},  imem_addr,        32'h0000_3000);
    check({tag, "_valid"}, 32'(if_id_valid), 32'h0000_0000);
    check({tag, "_pc"},    if_id_pc,         32'h0000_0000);
    check({tag, "_instr"}, if_id_instr,      32'h0000_0000);
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    mem_lat        = 1;
    mem_addr       = 32'h0000_0000;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    id_stall       = 1'b0;

    // Reset state (E1, E2)
    tick();
    tick();
    check_reset_values("rst");
    reset = 1'b1;

    // First request right after reset release, then latency-1 stream
    tick();  // E3
    check("req0_strobe", 32'(imem_req), 32'h0000_0001);
    check("req0_addr",   imem_addr,     32'h0000_3000);
    tick();  // E4
    check("wait0_req",   32'(imem_req),    32'h0000_0000);
    check("wait0_valid", 32'(if_id_valid), 32'h0000_0000);
    tick();  // E5
    check("ifid0_valid", 32'(if_id_valid), 32'h0000_0001);
    check("ifid0_pc",    if_id_pc,         32'h0000_3000);
    check("ifid0_instr", if_id_instr,      32'hA5A5_95A5);
    check("req1_addr",   imem_addr,        32'h0000_3004);
    check("req1_strobe", 32'(imem_req),    32'h0000_0001);
    tick();  // E6
    tick();  // E7
    check("ifid1_pc",    if_id_pc,      32'h0000_3004);
    check("ifid1_instr", if_id_instr,   32'hA5A5_95A1);
    check("req2_addr",   imem_addr,     32'h0000_3008);
    check("req2_strobe", 32'(imem_req), 32'h0000_0001);

    // Stall for 5 cycles while the 0x3008 response arrives
    id_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();  // E8..E12
      check("stall_valid", 32'(if_id_valid), 32'h0000_0001);
      check("stall_pc",    if_id_pc,         32'h0000_3004);
      check("stall_instr", if_id_instr,      32'hA5A5_95A1);
      check("stall_noreq", 32'(imem_req),    32'h0000_0000);
    end
    id_stall = 1'b0;
    tick();  // E13
    check("unstall_pc",    if_id_pc,      32'h0000_3008);
    check("unstall_instr", if_id_instr,   32'hA5A5_95AD);
    check("unstall_req",   32'(imem_req), 32'h0000_0001);
    check("unstall_addr",  imem_addr,     32'h0000_300C);

    // Redirect to 0x3400 while waiting on a latency-3 response
    mem_lat = 3;
    tick();  // E14
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3400;
    tick();  // E15
    redirect_valid = 1'b0;
    check("redir_wait_valid", 32'(if_id_valid), 32'h0000_0000);
    check("redir_wait_noreq", 32'(imem_req),    32'h0000_0000);
    tick();  // E16
    check("redir_wait_hold", 32'(imem_req), 32'h0000_0000);
    tick();  // E17
    check("redir_req",       32'(imem_req),    32'h0000_0001);
    check("redir_addr",      imem_addr,        32'h0000_3400);
    check("redir_discarded", 32'(if_id_valid), 32'h0000_0000);
    mem_lat = 1;
    tick();  // E18
    tick();  // E19
    check("redir_ifid_valid", 32'(if_id_valid), 32'h0000_0001);
    check("redir_ifid_pc",    if_id_pc,         32'h0000_3400);
    check("redir_ifid_instr", if_id_instr,      32'hA5A5_91A5);

    // Redirect coincident with stall and valid IF/ID; unaligned target
    id_stall       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3013;
    tick();  // E20
    redirect_valid = 1'b0;
    id_stall       = 1'b0;
    check("flush_valid", 32'(if_id_valid), 32'h0000_0000);
    check("flush_instr", if_id_instr,      32'h0000_0000);
    tick();  // E21
    check("align_req",  32'(imem_req), 32'h0000_0001);
    check("align_addr", imem_addr,     32'h0000_3010);
    tick();  // E22
    tick();  // E23
    check("align_ifid_pc",    if_id_pc,    32'h0000_3010);
    check("align_ifid_instr", if_id_instr, 32'hA5A5_95B5);

    // Redirect to the top word; the following sequential fetch wraps to 0
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();  // E24
    redirect_valid = 1'b0;
    tick();  // E25
    check("top_req",  32'(imem_req), 32'h0000_0001);
    check("top_addr", imem_addr,     32'hFFFF_FFFC);
    tick();  // E26
    tick();  // E27
    check("top_ifid_pc",    if_id_pc,      32'hFFFF_FFFC);
    check("top_ifid_instr", if_id_instr,   32'h5A5A_5A59);
    check("wrap_req",       32'(imem_req), 32'h0000_0001);
    check("wrap_addr",      imem_addr,     32'h0000_0000);

    // One-cycle reset mid-stream
    reset = 1'b0;
    tick();  // E28
    check_reset_values("mid_rst");
    reset = 1'b1;
    tick();  // E29
    check("restart_req",  32'(imem_req), 32'h0000_0001);
    check("restart_addr", imem_addr,     32'h0000_3000);
    tick();  // E30
    tick();  // E31
    check("restart_valid", 32'(if_id_valid), 32'h0000_0001);
    check("restart_pc",    if_id_pc,         32'h0000_3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that consumes next-PC decisions and drives the pipeline front end. Holds the architectural fetch PC, issues single-outstanding requests to instruction memory over a req/rvalid handshake, and loads the IF/ID pipeline register with `{pc, instr}`. Sits between the next-PC logic (redirect source) and the decode stage (stall/flush source).

## Interface
- `RESET_PC`, 32'h0000_3000, first fetch address after reset
- `NOP_INSTR`, 32'h0000_0000, instruction value held in IF/ID when invalid
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `redirect_valid`  in  1  next-PC logic demands a non-sequential PC (branch taken, j, jal, jr)
- `redirect_pc`  in  32  target PC; bits [1:0] ignored, forced to 00
- `id_stall`  in  1  decode cannot accept; IF/ID must hold
- `imem_req`  out  1  one-cycle request strobe
- `imem_addr`  out  32  word address of request, valid while `imem_req`=1
- `imem_rvalid`  in  1  read data valid, exactly one pulse per request, ≥1 cycle after `imem_req`
- `imem_rdata`  in  32  instruction word
- `if_id_valid`  out  1  IF/ID holds a live instruction
- `if_id_pc`  out  32  PC of instruction in IF/ID
- `if_id_instr`  out  32  instruction in IF/ID

## Operation
- States: `S_REQ` (issue request), `S_WAIT` (awaiting rvalid), `S_HOLD` (data buffered, IF/ID blocked).
- `S_REQ`: `imem_req`=1, `imem_addr`=`fetch_pc`; next `S_WAIT`.
- `S_WAIT` on `imem_rvalid`:
  - kill bit set: discard data, clear kill, next `S_REQ` (fetch_pc already holds target).
  - IF/ID can accept (`!id_stall || !if_id_valid`): load IF/ID `{fetch_pc, imem_rdata}`, valid=1, `fetch_pc`+=4, next `S_REQ`.
  - else: store rdata in hold buffer, next `S_HOLD`.
- `S_HOLD`: when IF/ID can accept, load from buffer, `fetch_pc`+=4, next `S_REQ`.
- Redirect (`redirect_valid`=1), any state, highest priority:
  - `fetch_pc` ← `{redirect_pc[31:2],2'b00}`; IF/ID valid←0, instr←`NOP_INSTR`, regardless of `id_stall`.
  - in `S_WAIT` without rvalid this cycle: set kill, stay `S_WAIT`.
  - in `S_WAIT` with rvalid this cycle: discard data, next `S_REQ`.
  - in `S_HOLD` or `S_REQ`: drop buffer / let request go out only if not yet issued — in `S_REQ` the strobe still issues for old `fetch_pc`; set kill, next `S_WAIT`.
- `id_stall` with IF/ID valid and no redirect: IF/ID outputs hold bit-exact.
- `fetch_pc` arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset (`reset`=0 at edge): state `S_REQ`, `fetch_pc`=`RESET_PC`, kill=0, `imem_req`=0 during reset cycles, `imem_addr`=`RESET_PC`, `if_id_valid`=0, `if_id_pc`=0, `if_id_instr`=`NOP_INSTR`.
- First `imem_req` in first cycle with `reset`=1.
- All outputs registered or decoded from state register only; no input→output combinational path.
- Memory latency 1: req cycle N, rvalid N+1, `if_id_valid` visible N+2; throughput one instruction per 2 cycles.
- Reset asserted mid-`S_WAIT`: outstanding response after reset release must be ignored — kill bit set on reset exit is not available, so memory is required to be reset together with this block.

## Structure
- Shared package: state enum (`S_REQ`,`S_WAIT`,`S_HOLD`), `RESET_PC` default, `NOP_INSTR`.
- One sub-module: `if_id_reg` (load/hold/flush register for `{valid, pc, instr}`).

## Test plan
- Reset release, latency-1 memory returning `instr = addr ^ 32'hA5A5_A5A5` -> requests at 0x3000, 0x3004, 0x3008; IF/ID shows pc 0x3000 two cycles after first req.
- `id_stall`=1 for 5 cycles while response arrives -> `S_HOLD`; IF/ID unchanged; no new `imem_req`; after release IF/ID takes buffered word, next req at PC+4.
- Redirect to 0x3400 while in `S_WAIT` (latency 3) -> old response discarded, `if_id_valid`=0, next `imem_req` addr 0x3400.
- Redirect coincident with `id_stall`=1 and `if_id_valid`=1 -> IF/ID flushed (valid 0, instr `NOP_INSTR`) same edge.
- `redirect_pc`=0x0000_3013 -> fetch at 0x3010; redirect to 0xFFFF_FFFC -> following sequential req 0x0000_0000.
- `reset`=0 for one cycle mid-stream -> all outputs at reset values, restart at 0x3000.
